// File: rtl/track_meter_pkg.sv
// rtl/track_meter_pkg.sv - shared types for the track period meter
package track_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam int REC_IDX_W = 32;
  localparam int REC_PER_W = 32;
  localparam int REC_W     = REC_IDX_W + REC_PER_W;

  typedef struct packed {
    logic [REC_IDX_W-1:0] index;
    logic [REC_PER_W-1:0] period;
  } rec_t;

  function automatic logic [REC_PER_W-1:0] sat_inc(input logic [REC_PER_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/track_rec_fifo.sv
// rtl/track_rec_fifo.sv - first-word-fall-through record FIFO, push accepted when full if popping
module track_rec_fifo
  import track_meter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output logic valid,
  output logic full,
  output rec_t head
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Shift-down storage keeps the head in mem[0] so the outputs are plain registers.
  rec_t           mem   [DEPTH];
  rec_t           mem_n [DEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_n;
  logic [CW-1:0]  wr;
  logic           do_pop;
  logic           do_push;

  always_comb begin
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    mem_n   = mem;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      mem_n[DEPTH-1] = '0;
    end
    wr = count - CW'(do_pop);
    if (do_push) mem_n[wr[CW-2:0]] = push_data;
    count_n = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
      valid <= 1'b0;
      full  <= 1'b0;
    end else begin
      mem   <= mem_n;
      count <= count_n;
      valid <= (count_n != '0);
      full  <= (count_n == CW'(DEPTH));
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/track_period_meter.sv
// rtl/track_period_meter.sv - track-to-track period meter with record FIFO
// Optional watchdog enabled by defining TRACK_TIMEOUT_EN.
module track_period_meter
  import track_meter_pkg::*;
#(
  parameter real         TCQ            = 0.1,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pmt_start_en_i,
  input  logic        track_trigger_i,
  input  logic [31:0] track_index_i,
  input  logic        rec_ready_i,
  output logic        rec_valid_o,
  output logic [31:0] rec_index_o,
  output logic [31:0] rec_period_o,
  output logic        overflow_o,
  output logic        timeout_o
);

  state_t                state;
  logic [REC_PER_W-1:0]  count;
  logic                  start_q;
  logic                  start_rise;
  logic                  timeout_hit;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  rec_t                  push_rec;
  rec_t                  head;

  assign start_rise = pmt_start_en_i && !start_q;
  assign pop        = rec_valid_o && rec_ready_i;
  assign push       = (state == MEASURE) && pmt_start_en_i && track_trigger_i && !timeout_hit;
  assign push_rec   = '{index: track_index_i, period: count};

`ifdef TRACK_TIMEOUT_EN
  assign timeout_hit = (state != IDLE) && (count == TIMEOUT_CYCLES);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          timeout_o <= 1'b0;
    else if (state == IDLE && start_rise) timeout_o <= 1'b0;
    else if (timeout_hit)               timeout_o <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= '0;
      start_q    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      start_q <= pmt_start_en_i;
      if (push && fifo_full && !pop) overflow_o <= 1'b1;
      case (state)
        IDLE: begin
          count <= '0;
          if (start_rise) begin
            state      <= ARM;
            overflow_o <= 1'b0;
          end
        end
        default: begin
          if (!pmt_start_en_i) begin
            state <= IDLE;
            count <= '0;
          end else if (timeout_hit) begin
            // A stalled spindle restarts arming so no bogus period is ever recorded.
            state <= ARM;
            count <= '0;
          end else if (track_trigger_i) begin
            state <= MEASURE;
            count <= 32'd1;
          end else begin
            count <= sat_inc(count);
          end
        end
      endcase
    end
  end

  track_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .valid     (rec_valid_o),
    .full      (fifo_full),
    .head      (head)
  );

  assign rec_index_o  = head.index;
  assign rec_period_o = head.period;

endmodule

// File: tb/tb_track_period_meter.sv
// tb/tb_track_period_meter.sv - scoreboard bench for track_period_meter
module tb_track_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] tidx = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] ridx;
  logic [31:0] rper;
  logic        ovf;
  logic        tmo;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  track_period_meter #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (32'd1000)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pmt_start_en_i  (start),
    .track_trigger_i (trig),
    .track_index_i   (tidx),
    .rec_ready_i     (ready),
    .rec_valid_o     (valid),
    .rec_index_o     (ridx),
    .rec_period_o    (rper),
    .overflow_o      (ovf),
    .timeout_o       (tmo)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every handshake pops one expected record.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("unexpected_record", {ridx, rper}, 64'hDEAD);
      end else begin
        chk("record", {ridx, rper}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] idx);
    trig = 1'b1;
    tidx = idx;
    tick();
    trig = 1'b0;
  endtask

  task automatic gap_pulse(input int n, input logic [31:0] idx);
    repeat (n - 1) tick();
    pulse(idx);
  endtask

  task automatic expect_rec(input logic [31:0] idx, input logic [31:0] per);
    exp_q.push_back({idx, per});
  endtask

  task automatic restart();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
  endtask

  initial begin
    int pops_before;
    logic exp_tmo;

    tick();
    chk("reset_valid", valid, 1'b0);
    chk("reset_index", ridx, 32'd0);
    chk("reset_period", rper, 32'd0);
    chk("reset_overflow", ovf, 1'b0);
    chk("reset_timeout", tmo, 1'b0);
    rst = 1'b0;
    tick();

    // Basic scan: first trigger swallowed, then periods 100 and 120.
    ready = 1'b1;
    start = 1'b1;
    tick();
    repeat (8) tick();
    pulse(32'd0);
    expect_rec(32'd1, 32'd100);
    gap_pulse(100, 32'd1);
    expect_rec(32'd2, 32'd120);
    gap_pulse(120, 32'd2);
    repeat (4) tick();
    chk("basic_drained", exp_q.size(), 0);

    // Back-pressure, full-with-pop, then overflow.
    ready = 1'b0;
    restart();
    pulse(32'd0);
    for (int k = 1; k <= 4; k++) begin
      expect_rec(k, 32'd50);
      gap_pulse(50, k);
    end
    chk("full_valid", valid, 1'b1);
    chk("full_head", ridx, 32'd1);
    chk("full_no_overflow", ovf, 1'b0);
    expect_rec(32'd5, 32'd50);
    repeat (49) tick();
    ready = 1'b1;
    pulse(32'd5);
    ready = 1'b0;
    chk("simul_pop_overflow", ovf, 1'b0);
    chk("simul_pop_head", {ridx, rper}, {32'd2, 32'd50});
    gap_pulse(50, 32'd6);
    chk("drop_overflow", ovf, 1'b1);
    chk("drop_head_stable", {ridx, rper}, {32'd2, 32'd50});
    pops_before = n_pops;
    ready = 1'b1;
    repeat (8) tick();
    chk("drain_count", n_pops - pops_before, 4);
    chk("drain_empty", valid, 1'b0);

    // Stop/restart: no record on stop, restart clears overflow.
    start = 1'b0;
    repeat (3) tick();
    pulse(32'd99);
    start = 1'b1;
    pulse(32'd98);
    chk("restart_clears_overflow", ovf, 1'b0);
    repeat (9) tick();
    pulse(32'd20);
    expect_rec(32'd21, 32'd70);
    gap_pulse(70, 32'd21);
    repeat (30) tick();
    start = 1'b0;
    pulse(32'd97);
    repeat (3) tick();
    start = 1'b1;
    repeat (5) tick();
    pulse(32'd30);
    expect_rec(32'd31, 32'd45);
    gap_pulse(45, 32'd31);
    repeat (4) tick();
    chk("restart_drained", exp_q.size(), 0);

    // Reset mid-operation with three records queued.
    ready = 1'b0;
    restart();
    pulse(32'd40);
    gap_pulse(10, 32'd41);
    gap_pulse(10, 32'd42);
    gap_pulse(10, 32'd43);
    chk("pre_reset_head", {ridx, rper}, {32'd41, 32'd10});
    start = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", valid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_outputs", {valid, ridx, rper, ovf, tmo}, 67'd0);

    // Watchdog: 1000 idle cycles in ARM, then a 200-cycle track.
`ifdef TRACK_TIMEOUT_EN
    exp_tmo = 1'b1;
`else
    exp_tmo = 1'b0;
`endif
    ready = 1'b1;
    start = 1'b1;
    tick();
    chk("timeout_before", tmo, 1'b0);
    repeat (1005) tick();
    chk("timeout_flag", tmo, exp_tmo);
    pulse(32'd50);
    expect_rec(32'd51, 32'd200);
    gap_pulse(200, 32'd51);
    repeat (5) tick();
    chk("timeout_record_drained", exp_q.size(), 0);
    chk("timeout_sticky", tmo, exp_tmo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
